deser2x8_rx: RTL and testbench

- Receive-side deserializer for the two-lane high-speed link.
- Samples two serial lanes (Serial_B1, Serial_B2) on every rising edge of RxDDRClk and hunts for the HS sync byte.
- Once locked, reassembles W-bit bytes and presents them on RxByteHS with a one-cycle valid strobe.
- Sits between the lane front-end and the byte-level protocol/packet handler, mirroring the transmit serializer's bit ordering.

---
 rtl/deser2x8_rx_pkg.sv | 21 ++
 rtl/deser2x8_rx_if.sv | 39 +++
 rtl/deser2x8_rx_pair_shift_reg.sv | 22 ++
 rtl/deser2x8_rx.sv | 126 ++++++++++++
 tb/tb_deser2x8_rx.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/deser2x8_rx_pkg.sv
// Shared types and defaults for the two-lane HS receive deserializer.
package deser_pkg;

   localparam int unsigned W_DEF        = 8;
   localparam int unsigned HUNT_MAX_DEF = 32;
   localparam logic [7:0]  SYNC_DEF     = 8'hB8;

   // Pair-counter width for a byte of width w (at least one bit).
   function automatic int unsigned pcnt_width(input int unsigned w);
      return ($clog2(w / 2) > 0) ? $clog2(w / 2) : 1;
   endfunction

   localparam int unsigned PCNT_W = pcnt_width(W_DEF);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HUNT = 2'd1,
      DATA = 2'd2
   } state_t;

endpackage

// File: rtl/deser2x8_rx_if.sv
// Lane inputs and byte-level outputs of the receive deserializer.
interface deser2x8_rx_if #(
   parameter int unsigned W = deser_pkg::W_DEF
);

   logic         Serial_B1;
   logic         Serial_B2;
   logic         En;
   logic [W-1:0] RxByteHS;
   logic         RxValidHS;
   logic         RxSyncHS;
   logic         RxActiveHS;
   logic         ErrSotHS;

   // Lane front-end side: drives the lanes, consumes bytes.
   modport master (
      output Serial_B1,
      output Serial_B2,
      output En,
      input  RxByteHS,
      input  RxValidHS,
      input  RxSyncHS,
      input  RxActiveHS,
      input  ErrSotHS
   );

   // Deserializer side.
   modport slave (
      input  Serial_B1,
      input  Serial_B2,
      input  En,
      output RxByteHS,
      output RxValidHS,
      output RxSyncHS,
      output RxActiveHS,
      output ErrSotHS
   );

endinterface

// File: rtl/deser2x8_rx_pair_shift_reg.sv
// W/2-pair shift register; each new (B2,B1) pair enters at the MSB end.
module pair_shift_reg #(
   parameter int unsigned W = deser_pkg::W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         shift,
   input  logic         b1,
   input  logic         b2,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         q <= '0;
      end else if (shift) begin
         q <= {b2, b1, q[W-1:2]};
      end
   end

endmodule

// File: rtl/deser2x8_rx.sv
// Two-lane HS receive deserializer: hunts for SYNC, then emits one byte per W/2 cycles.
module deser2x8_rx
   import deser_pkg::*;
#(
   parameter int unsigned   W        = W_DEF,
   parameter logic [W-1:0]  SYNC     = W'(SYNC_DEF),
   parameter int unsigned   HUNT_MAX = HUNT_MAX_DEF
) (
   input  logic             RxDDRClk,
   input  logic             Rx_RST,
   deser2x8_rx_if.slave     bus
);

   localparam int unsigned PAIRS  = W / 2;
   localparam int unsigned CNT_W  = pcnt_width(W);
   localparam int unsigned HCNT_W = $clog2(HUNT_MAX + 1);

   state_t              state, state_nx;
   logic [CNT_W-1:0]    pcnt, pcnt_nx;
   logic [HCNT_W-1:0]   hcnt, hcnt_nx;
   logic [W-1:0]        sr;
   logic                sr_clr, sr_shift;

   logic [W-1:0]        byte_q, byte_nx;
   logic                valid_q, valid_nx;
   logic                sync_q, sync_nx;
   logic                active_q;
   logic                err_q, err_nx;

   pair_shift_reg #(.W(W)) u_sr (
      .clk   (RxDDRClk),
      .rst   (Rx_RST),
      .clr   (sr_clr),
      .shift (sr_shift),
      .b1    (bus.Serial_B1),
      .b2    (bus.Serial_B2),
      .q     (sr)
   );

   // State, counters and registered outputs.
   always_ff @(posedge RxDDRClk) begin
      if (Rx_RST) begin
         state    <= IDLE;
         pcnt     <= '0;
         hcnt     <= '0;
         byte_q   <= '0;
         valid_q  <= 1'b0;
         sync_q   <= 1'b0;
         active_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state    <= state_nx;
         pcnt     <= pcnt_nx;
         hcnt     <= hcnt_nx;
         byte_q   <= byte_nx;
         valid_q  <= valid_nx;
         sync_q   <= sync_nx;
         active_q <= (state_nx == DATA);
         err_q    <= err_nx;
      end
   end

   // Next-state: sr already holds the pair sampled at the last edge, so a match
   // here surfaces as RxSyncHS one edge after the final SYNC pair.
   always_comb begin
      state_nx = state;
      pcnt_nx  = pcnt;
      hcnt_nx  = hcnt;
      byte_nx  = byte_q;
      valid_nx = 1'b0;
      sync_nx  = 1'b0;
      err_nx   = 1'b0;
      sr_clr   = 1'b0;
      sr_shift = 1'b0;

      unique case (state)
         IDLE: begin
            sr_clr  = 1'b1;
            pcnt_nx = '0;
            hcnt_nx = '0;
            if (bus.En) begin
               state_nx = HUNT;
            end
         end
         HUNT: begin
            sr_shift = 1'b1;
            hcnt_nx  = hcnt + HCNT_W'(1);
            if (sr == SYNC) begin
               state_nx = DATA;
               sync_nx  = 1'b1;
               pcnt_nx  = '0;
            end else if (hcnt == HCNT_W'(HUNT_MAX - 1)) begin
               state_nx = IDLE;
               err_nx   = 1'b1;
            end
         end
         DATA: begin
            sr_shift = 1'b1;
            if (pcnt == CNT_W'(PAIRS - 1)) begin
               pcnt_nx  = '0;
               byte_nx  = sr;
               valid_nx = 1'b1;
            end else begin
               pcnt_nx = pcnt + CNT_W'(1);
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase

      // Dropping En abandons the burst; a lock or timeout in flight is not reported.
      if (!bus.En) begin
         state_nx = IDLE;
         sync_nx  = 1'b0;
         err_nx   = 1'b0;
      end
   end

   assign bus.RxByteHS   = byte_q;
   assign bus.RxValidHS  = valid_q;
   assign bus.RxSyncHS   = sync_q;
   assign bus.RxActiveHS = active_q;
   assign bus.ErrSotHS   = err_q;

endmodule

// File: tb/tb_deser2x8_rx.sv
// Directed bench for deser2x8_rx: lock, payload cadence, odd-offset sync, timeout, En drop, reset.
module tb_deser2x8_rx;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   deser2x8_rx_if bus ();

   deser2x8_rx dut (
      .RxDDRClk (clk),
      .Rx_RST   (rst),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic v, input logic s, input logic a,
                          input logic e, input logic [7:0] b);
      chk({tag, ".valid"},  32'(bus.RxValidHS),  32'(v));
      chk({tag, ".sync"},   32'(bus.RxSyncHS),   32'(s));
      chk({tag, ".active"}, 32'(bus.RxActiveHS), 32'(a));
      chk({tag, ".err"},    32'(bus.ErrSotHS),   32'(e));
      chk({tag, ".byte"},   32'(bus.RxByteHS),   32'(b));
   endtask

   // Drive one pair, take one rising edge, settle before sampling.
   task automatic send(input logic b1, input logic b2);
      bus.Serial_B1 = b1;
      bus.Serial_B2 = b2;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int npulse;
      int first_err;
      int second_err;
      int bad;

      checks        = 0;
      failures      = 0;
      rst           = 1'b1;
      bus.En        = 1'b0;
      bus.Serial_B1 = 1'b0;
      bus.Serial_B2 = 1'b0;

      send(0, 0);
      send(0, 0);
      chk_out("reset", 0, 0, 0, 0, 8'h00);
      rst = 1'b0;
      send(0, 0);
      chk_out("idle_en0", 0, 0, 0, 0, 8'h00);

      // Lock on SYNC 0xB8
      bus.En = 1'b1;
      send(0, 0);
      send(0, 0); send(0, 1); send(1, 1); send(0, 1);
      chk_out("pre_sync", 0, 0, 0, 0, 8'h00);

      // Payload 0xAB
      send(1, 1);
      chk_out("sync", 0, 1, 1, 0, 8'h00);
      send(0, 1);
      chk_out("ab_p1", 0, 0, 1, 0, 8'h00);
      send(0, 1); send(0, 1);
      chk_out("ab_p3", 0, 0, 1, 0, 8'h00);

      // Payload 0x00
      send(0, 0);
      chk_out("byte_ab", 1, 0, 1, 0, 8'hAB);
      send(0, 0);
      chk_out("after_ab", 0, 0, 1, 0, 8'hAB);
      send(0, 0);
      send(0, 0);
      chk_out("gap_00", 0, 0, 1, 0, 8'hAB);

      // Payload 0xFF
      send(1, 1);
      chk_out("byte_00", 1, 0, 1, 0, 8'h00);
      send(1, 1); send(1, 1); send(1, 1);
      chk_out("gap_ff", 0, 0, 1, 0, 8'h00);

      // Payload 0xB8 (must be plain data)
      send(0, 0);
      chk_out("byte_ff", 1, 0, 1, 0, 8'hFF);
      send(0, 1); send(1, 1); send(0, 1);
      chk_out("b8_in", 0, 0, 1, 0, 8'hFF);

      // Two pairs of a further byte, then drop En
      send(1, 0);
      chk_out("byte_b8", 1, 0, 1, 0, 8'hB8);
      send(1, 0);
      chk_out("no_resync", 0, 0, 1, 0, 8'hB8);
      bus.En = 1'b0;
      send(1, 0);
      chk_out("en_drop", 0, 0, 0, 0, 8'hB8);
      send(0, 0);
      chk_out("idle_hold", 0, 0, 0, 0, 8'hB8);

      // Re-enable; one junk pair shifts SYNC to an odd offset; payload 0x3C
      bus.En = 1'b1;
      send(0, 0);
      chk_out("rehunt", 0, 0, 0, 0, 8'hB8);
      send(1, 0);
      send(0, 0); send(0, 1); send(1, 1); send(0, 1);
      chk_out("odd_pre_sync", 0, 0, 0, 0, 8'hB8);
      send(0, 0);
      chk_out("odd_sync", 0, 1, 1, 0, 8'hB8);
      send(1, 1); send(1, 1); send(0, 0);
      chk_out("odd_gap", 0, 0, 1, 0, 8'hB8);
      send(1, 1);
      chk_out("byte_3c", 1, 0, 1, 0, 8'h3C);

      // Reset in the middle of the next byte
      send(1, 1);
      rst = 1'b1;
      send(0, 0);
      chk_out("rst_mid", 0, 0, 0, 0, 8'h00);
      rst    = 1'b0;
      bus.En = 1'b0;
      send(0, 0);

      // Hunt timeout with all-zero lanes; En stays high so HUNT is re-entered
      npulse     = 0;
      first_err  = 0;
      second_err = 0;
      bad        = 0;
      bus.En     = 1'b1;
      for (int i = 1; i <= 70; i++) begin
         send(0, 0);
         if (bus.ErrSotHS) begin
            npulse++;
            if (npulse == 1) first_err = i;
            else if (npulse == 2) second_err = i;
         end
         if (bus.RxSyncHS || bus.RxActiveHS || bus.RxValidHS) bad++;
      end
      chk("err_count",  32'(npulse),     32'd2);
      chk("err_first",  32'(first_err),  32'd33);
      chk("err_second", 32'(second_err), 32'd66);
      chk("hunt_quiet", 32'(bad),        32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
